cla_byte_serial_seq: RTL

- Byte-serial multi-byte add/subtract sequencer that sits directly around the 8-bit carry-lookahead adder stage.
- Feeds the adder one operand byte pair plus carry-in per cycle, and consumes its 8-bit sum and carry-out.
- Chains the carry in a register across NBYTES cycles to produce wide ALU results, e.g. 32-bit, without a wide adder.
- Used by the datapath for wide ADD/SUB instructions.

---
 rtl/cla_byte_serial_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cla_byte_serial_seq.sv
// Byte-serial wide add/subtract sequencer around an external 8-bit CLA stage.
// Ports: clk, rst_n (async low); start/sub/op_a/op_b request; busy/done/result/
// cout/zero/ovf status; cla_a/cla_b/cla_cin to adder, cla_sum/cla_cout back.
// Optional macro CLA_SEQ_OVF_EN enables the signed overflow flag (else ovf=0).
module cla_byte_serial_seq #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         zero,
    output logic         ovf,
    output logic [7:0]   cla_a,
    output logic [7:0]   cla_b,
    output logic         cla_cin,
    input  logic [7:0]   cla_sum,
    input  logic         cla_cout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam int             IW   = $clog2(NBYTES);
    localparam logic [IW-1:0]  LAST = IW'(NBYTES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_result;
    logic [W-1:0]  w_result_nxt;
    logic          r_carry;
    logic          r_cout;
    logic          r_zero;
    logic          w_accept;
    logic          w_run;
    logic          w_last;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_run    = (r_state == S_RUN);
    assign w_last   = w_run && (r_idx == LAST);

    assign result = r_result;
    assign cout   = r_cout;
    assign zero   = r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        done    = 1'b0;
        cla_a   = 8'h00;
        cla_b   = 8'h00;
        cla_cin = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                cla_a   = r_a[8*r_idx +: 8];
                cla_b   = r_b[8*r_idx +: 8];
                cla_cin = r_carry;
                if (r_idx == LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Result with the current byte merged in, so zero sees the full word
    // on the final byte edge.
    always_comb begin
        w_result_nxt = r_result;
        w_result_nxt[8*r_idx +: 8] = cla_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            // Subtract as A + ~B + 1: invert B now, seed carry with 1.
            r_a      <= op_a;
            r_b      <= sub ? ~op_b : op_b;
            r_carry  <= sub;
            r_idx    <= '0;
            r_result <= '0;
        end else if (w_run) begin
            r_result <= w_result_nxt;
            r_carry  <= cla_cout;
            if (w_last) begin
                r_idx  <= '0;
                r_cout <= cla_cout;
                r_zero <= (w_result_nxt == '0);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

`ifdef CLA_SEQ_OVF_EN
    logic r_ovf;

    // r_b is already inverted for SUB, so one rule covers both ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= (r_a[W-1] == r_b[W-1]) && (cla_sum[7] != r_a[W-1]);
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule
